// File: rtl/adc_sample_sequencer_pkg.sv
// Shared types and constants for the XADC two-channel sample sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    WAIT_A,
    REQ_B,
    WAIT_B,
    PUBLISH
  } state_e;

  localparam logic [6:0] ADDR_5V_DEF    = 7'h13;
  localparam logic [6:0] ADDR_OTHER_DEF = 7'h1B;

  localparam int DRP_DATA_MSB = 15;
  localparam int DRP_DATA_LSB = 4;
  localparam int CODE_W       = DRP_DATA_MSB - DRP_DATA_LSB + 1;

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// DRP bus towards the XADC plus the published sample pair towards the rail controllers.
interface adc_sample_sequencer_if;
  import adc_seq_pkg::*;

  logic              drp_den_out;
  logic              drp_dwe_out;
  logic [6:0]        drp_daddr_out;
  logic              drp_drdy_in;
  logic [15:0]       drp_do_in;
  logic [CODE_W-1:0] volt_5v_out;
  logic [CODE_W-1:0] volt_other_out;
  logic              drdy_out;
  logic              sample_valid;

  modport master (
    output drp_den_out, drp_dwe_out, drp_daddr_out,
    output volt_5v_out, volt_other_out, drdy_out, sample_valid,
    input  drp_drdy_in, drp_do_in
  );

  modport slave (
    input  drp_den_out, drp_dwe_out, drp_daddr_out,
    input  volt_5v_out, volt_other_out, drdy_out, sample_valid,
    output drp_drdy_in, drp_do_in
  );

endinterface

// File: rtl/adc_sample_sequencer_avg4.sv
// Single-channel 4-tap boxcar: avg_o is the mean of code_i and the last three committed codes.
// load_i preloads the whole history with code_i so the first result equals the raw code.
module sample_avg4
  import adc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_in,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [CODE_W-1:0] code_i,
  output logic [CODE_W-1:0] avg_o
);

  logic [CODE_W-1:0] h0_q, h1_q, h2_q;
  logic [CODE_W-1:0] h0_d, h1_d, h2_d;
  logic [CODE_W+1:0] sum;

  assign sum   = {2'b00, code_i} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
  assign avg_o = load_i ? code_i : sum[CODE_W+1:2];

  always_comb begin
    h0_d = h0_q;
    h1_d = h1_q;
    h2_d = h2_q;
    if (load_i) begin
      h0_d = code_i;
      h1_d = code_i;
      h2_d = code_i;
    end else if (en_i) begin
      h0_d = code_i;
      h1_d = h0_q;
      h2_d = h1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      h0_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// On each XADC end-of-conversion, reads two aux channels over DRP and publishes the pair with drdy_out.
// SAMPLE_AVG_EN: when defined, each channel is published through a 4-tap boxcar (sample_avg4).
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter logic [6:0] ADDR_5V    = ADDR_5V_DEF,
  parameter logic [6:0] ADDR_OTHER = ADDR_OTHER_DEF,
  parameter int         TIMEOUT    = 64,
  parameter int         TIMEOUT_W  = 7
) (
  input  logic                   clk,
  input  logic                   reset_in,
  input  logic                   eoc_in,
  adc_sample_sequencer_if.master bus,
  output logic                   timeout_err,
  output logic                   overrun_err
);

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;
  logic [6:0]            daddr_q, daddr_d;
  logic [CODE_W-1:0]     temp_a_q, temp_a_d;
  logic [CODE_W-1:0]     temp_b_q, temp_b_d;
  logic [CODE_W-1:0]     volt_5v_q, volt_5v_d;
  logic [CODE_W-1:0]     volt_other_q, volt_other_d;
  logic                  drdy_q, drdy_d;
  logic                  valid_q, valid_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  ovr_err_q, ovr_err_d;

  logic [CODE_W-1:0]     drp_code;
  logic                  tmo_hit;
  logic                  publish;
  logic [CODE_W-1:0]     pub_5v, pub_other;
  logic                  unused_drp_lsbs;

  assign drp_code        = bus.drp_do_in[DRP_DATA_MSB:DRP_DATA_LSB];
  assign unused_drp_lsbs = ^bus.drp_do_in[DRP_DATA_LSB-1:0];
  assign tmo_hit         = (tmo_q == TIMEOUT_W'(TIMEOUT));
  assign publish         = (state_q == PUBLISH);

`ifdef SAMPLE_AVG_EN
  // History commits only in PUBLISH, so a timed-out pair never reaches it.
  sample_avg4 u_avg_5v (
    .clk      (clk),
    .reset_in (reset_in),
    .load_i   (publish && !valid_q),
    .en_i     (publish && valid_q),
    .code_i   (temp_a_q),
    .avg_o    (pub_5v)
  );

  sample_avg4 u_avg_other (
    .clk      (clk),
    .reset_in (reset_in),
    .load_i   (publish && !valid_q),
    .en_i     (publish && valid_q),
    .code_i   (temp_b_q),
    .avg_o    (pub_other)
  );
`else
  assign pub_5v    = temp_a_q;
  assign pub_other = temp_b_q;
`endif

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    tmo_d        = tmo_q;
    daddr_d      = daddr_q;
    temp_a_d     = temp_a_q;
    temp_b_d     = temp_b_q;
    volt_5v_d    = volt_5v_q;
    volt_other_d = volt_other_q;
    drdy_d       = 1'b0;
    valid_d      = valid_q;
    tmo_err_d    = 1'b0;
    ovr_err_d    = 1'b0;

    // Only one conversion can be queued; a second one while busy is dropped.
    if (eoc_in && state_q != IDLE) begin
      pending_d = 1'b1;
      ovr_err_d = pending_q;
    end

    unique case (state_q)
      IDLE: begin
        if (eoc_in || pending_q) begin
          state_d   = REQ_A;
          daddr_d   = ADDR_5V;
          pending_d = pending_q && eoc_in;
        end
      end
      REQ_A: begin
        state_d = WAIT_A;
        tmo_d   = '0;
      end
      WAIT_A: begin
        if (bus.drp_drdy_in) begin
          temp_a_d = drp_code;
          state_d  = REQ_B;
          daddr_d  = ADDR_OTHER;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          temp_a_d  = '0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      REQ_B: begin
        state_d = WAIT_B;
        tmo_d   = '0;
      end
      WAIT_B: begin
        if (bus.drp_drdy_in) begin
          temp_b_d = drp_code;
          state_d  = PUBLISH;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          temp_a_d  = '0;
          temp_b_d  = '0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PUBLISH: begin
        volt_5v_d    = pub_5v;
        volt_other_d = pub_other;
        drdy_d       = 1'b1;
        valid_d      = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      tmo_q        <= '0;
      daddr_q      <= '0;
      temp_a_q     <= '0;
      temp_b_q     <= '0;
      volt_5v_q    <= '0;
      volt_other_q <= '0;
      drdy_q       <= 1'b0;
      valid_q      <= 1'b0;
      tmo_err_q    <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      tmo_q        <= tmo_d;
      daddr_q      <= daddr_d;
      temp_a_q     <= temp_a_d;
      temp_b_q     <= temp_b_d;
      volt_5v_q    <= volt_5v_d;
      volt_other_q <= volt_other_d;
      drdy_q       <= drdy_d;
      valid_q      <= valid_d;
      tmo_err_q    <= tmo_err_d;
      ovr_err_q    <= ovr_err_d;
    end
  end

  assign bus.drp_den_out    = (state_q == REQ_A) || (state_q == REQ_B);
  assign bus.drp_dwe_out    = 1'b0;
  assign bus.drp_daddr_out  = daddr_q;
  assign bus.volt_5v_out    = volt_5v_q;
  assign bus.volt_other_out = volt_other_q;
  assign bus.drdy_out       = drdy_q;
  assign bus.sample_valid   = valid_q;
  assign timeout_err        = tmo_err_q;
  assign overrun_err        = ovr_err_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: DRP responder model, pair scoreboard, vector table and corner sequences.
module tb_adc_sample_sequencer;
  import adc_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_in;
  logic eoc_in;
  logic timeout_err;
  logic overrun_err;

  adc_sample_sequencer_if bus ();

  adc_sample_sequencer dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .eoc_in      (eoc_in),
    .bus         (bus.master),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] v5;
    logic [11:0] vo;
  } pair_t;

  typedef struct {
    int          da;
    int          db;
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_drdy = 0, n_to = 0, n_ov = 0;
  int last_drdy_cyc = 0, last_to_cyc = 0, last_den_a_cyc = 0;
  int dly_a = 1, dly_b = 1;
  logic [15:0] data_a = '0, data_b = '0;
  int rsp_cnt = 0;
  logic [15:0] rsp_dat = '0;
  logic rsp_is_b = 1'b0;
  logic rsp_ok = 1'b0;
  logic [11:0] srv_a = '0;
  logic [11:0] exp_5v = '0, exp_oth = '0;
  pair_t sb[$];
`ifdef SAMPLE_AVG_EN
  logic [11:0] ma[3];
  logic [11:0] mb[3];
  logic m_init = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void push_pair(input logic [11:0] a, input logic [11:0] b);
    pair_t p;
`ifdef SAMPLE_AVG_EN
    logic [13:0] sa, sbs;
    if (!m_init) begin
      for (int i = 0; i < 3; i++) begin
        ma[i] = a;
        mb[i] = b;
      end
      m_init = 1'b1;
      p.v5 = a;
      p.vo = b;
    end else begin
      sa  = {2'b00, a} + {2'b00, ma[0]} + {2'b00, ma[1]} + {2'b00, ma[2]};
      sbs = {2'b00, b} + {2'b00, mb[0]} + {2'b00, mb[1]} + {2'b00, mb[2]};
      p.v5 = sa[13:2];
      p.vo = sbs[13:2];
      ma[2] = ma[1]; ma[1] = ma[0]; ma[0] = a;
      mb[2] = mb[1]; mb[1] = mb[0]; mb[0] = b;
    end
`else
    p.v5 = a;
    p.vo = b;
`endif
    sb.push_back(p);
  endfunction

  function automatic void model_reset();
    sb.delete();
    exp_5v = '0;
    exp_oth = '0;
`ifdef SAMPLE_AVG_EN
    m_init = 1'b0;
`endif
  endfunction

  // One clock cycle: observe outputs mid-cycle, then drive the DRP responder and eoc_in.
  task automatic step(input logic eoc);
    pair_t p;
    @(negedge clk);
    cyc++;
    if (bus.drdy_out === 1'b1) begin
      n_drdy++;
      last_drdy_cyc = cyc;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_drdy: got strobe at cycle %0d, required no strobe", cyc);
      end else begin
        p = sb.pop_front();
        chk("volt_5v", 32'(bus.volt_5v_out), 32'(p.v5));
        chk("volt_other", 32'(bus.volt_other_out), 32'(p.vo));
        chk("sample_valid_at_drdy", 32'(bus.sample_valid), 32'd1);
        exp_5v = p.v5;
        exp_oth = p.vo;
      end
    end
    if (timeout_err === 1'b1) begin
      n_to++;
      last_to_cyc = cyc;
    end
    if (overrun_err === 1'b1) n_ov++;

    bus.drp_drdy_in = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        bus.drp_drdy_in = 1'b1;
        bus.drp_do_in = rsp_dat;
        if (!rsp_is_b) srv_a = rsp_dat[15:4];
        else if (rsp_ok) push_pair(srv_a, rsp_dat[15:4]);
      end
    end
    if (bus.drp_den_out === 1'b1) begin
      chk("den_addr", 32'(bus.drp_daddr_out == 7'h13 || bus.drp_daddr_out == 7'h1B), 32'd1);
      if (bus.drp_daddr_out == 7'h13) begin
        last_den_a_cyc = cyc;
        rsp_cnt = dly_a;
        rsp_dat = data_a;
        rsp_is_b = 1'b0;
        rsp_ok = (dly_a >= 1 && dly_a <= 65);
      end else begin
        rsp_cnt = dly_b;
        rsp_dat = data_b;
        rsp_is_b = 1'b1;
        rsp_ok = (dly_b >= 1 && dly_b <= 65);
      end
    end
    eoc_in = eoc;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_volt_5v"}, 32'(bus.volt_5v_out), 32'd0);
    chk({tag, "_volt_other"}, 32'(bus.volt_other_out), 32'd0);
    chk({tag, "_drdy"}, 32'(bus.drdy_out), 32'd0);
    chk({tag, "_sample_valid"}, 32'(bus.sample_valid), 32'd0);
    chk({tag, "_den"}, 32'(bus.drp_den_out), 32'd0);
    chk({tag, "_daddr"}, 32'(bus.drp_daddr_out), 32'd0);
    chk({tag, "_dwe"}, 32'(bus.drp_dwe_out), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_overrun_err"}, 32'(overrun_err), 32'd0);
  endtask

  task automatic run_until_drdy(input int b0, input int want);
    for (int k = 0; k < 400 && (n_drdy - b0) < want; k++) step(1'b0);
  endtask

  vec_t tbl[7];
  int   e, b0, t0, o0;

  initial begin
    tbl[0] = '{da: 2,  db: 3,  a: 16'hC4E0, b: 16'h8000};
    tbl[1] = '{da: 1,  db: 1,  a: 16'h1230, b: 16'hFFF0};
    tbl[2] = '{da: 65, db: 1,  a: 16'hABC0, b: 16'h5550};
    tbl[3] = '{da: 1,  db: 65, a: 16'h0010, b: 16'h0020};
    tbl[4] = '{da: 3,  db: 0,  a: 16'h7770, b: 16'h6660};
    tbl[5] = '{da: 66, db: 2,  a: 16'h1110, b: 16'h2220};
    tbl[6] = '{da: 5,  db: 2,  a: 16'h3210, b: 16'h4560};

    reset_in = 1'b1;
    eoc_in = 1'b0;
    bus.drp_drdy_in = 1'b0;
    bus.drp_do_in = '0;
    repeat (3) step(1'b0);
    check_cleared("reset");
    reset_in = 1'b0;
    model_reset();
    repeat (2) step(1'b0);

    // Vector table: dX in 1..65 answers in time, 0 never answers, 66 answers one cycle too late.
    for (int i = 0; i < 7; i++) begin
      logic a_ok, b_ok;
      a_ok = (tbl[i].da >= 1 && tbl[i].da <= 65);
      b_ok = (tbl[i].db >= 1 && tbl[i].db <= 65);
      dly_a = tbl[i].da;
      dly_b = tbl[i].db;
      data_a = tbl[i].a;
      data_b = tbl[i].b;
      b0 = n_drdy;
      t0 = n_to;
      step(1'b1);
      e = cyc;
      for (int k = 0; k < 300 && n_drdy == b0 && n_to == t0; k++) step(1'b0);
      repeat (3) step(1'b0);
      if (a_ok && b_ok) begin
        chk($sformatf("vec%0d_drdy_count", i), 32'(n_drdy - b0), 32'd1);
        chk($sformatf("vec%0d_latency", i), 32'(last_drdy_cyc - e), 32'(4 + tbl[i].da + tbl[i].db));
        chk($sformatf("vec%0d_no_timeout", i), 32'(n_to - t0), 32'd0);
      end else begin
        chk($sformatf("vec%0d_timeout_count", i), 32'(n_to - t0), 32'd1);
        chk($sformatf("vec%0d_timeout_cycle", i), 32'(last_to_cyc - e),
            a_ok ? 32'(68 + tbl[i].da) : 32'd67);
        chk($sformatf("vec%0d_no_drdy", i), 32'(n_drdy - b0), 32'd0);
        chk($sformatf("vec%0d_held_5v", i), 32'(bus.volt_5v_out), 32'(exp_5v));
        chk($sformatf("vec%0d_held_other", i), 32'(bus.volt_other_out), 32'(exp_oth));
      end
    end

    // Three eoc pulses inside one read sequence.
    dly_a = 3; dly_b = 3; data_a = 16'h2460; data_b = 16'h1350;
    b0 = n_drdy; o0 = n_ov;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    run_until_drdy(b0, 2);
    repeat (20) step(1'b0);
    chk("burst_overrun_count", 32'(n_ov - o0), 32'd1);
    chk("burst_drdy_count", 32'(n_drdy - b0), 32'd2);

    // eoc in the PUBLISH cycle is queued and restarts two cycles later.
    dly_a = 1; dly_b = 1; data_a = 16'h5A50; data_b = 16'hA5A0;
    b0 = n_drdy; o0 = n_ov;
    step(1'b1);
    e = cyc;
    repeat (4) step(1'b0);
    step(1'b1);
    run_until_drdy(b0, 2);
    repeat (3) step(1'b0);
    chk("pub_eoc_drdy_count", 32'(n_drdy - b0), 32'd2);
    chk("pub_eoc_restart_den", 32'(last_den_a_cyc - e), 32'd7);
    chk("pub_eoc_second_drdy", 32'(last_drdy_cyc - e), 32'd12);
    chk("pub_eoc_no_overrun", 32'(n_ov - o0), 32'd0);

    // Reset while waiting on the first read; the late answer must be ignored.
    dly_a = 10; dly_b = 1; data_a = 16'hEEE0; data_b = 16'hDDD0;
    b0 = n_drdy;
    step(1'b1);
    e = cyc;
    repeat (3) step(1'b0);
    reset_in = 1'b1;
    step(1'b0);
    reset_in = 1'b0;
    model_reset();
    step(1'b0);
    check_cleared("midreset");
    repeat (15) step(1'b0);
    chk("midreset_no_drdy", 32'(n_drdy - b0), 32'd0);
    chk("midreset_no_restart", 32'(last_den_a_cyc - e), 32'd1);
    chk("midreset_volt_5v_after_late", 32'(bus.volt_5v_out), 32'd0);
    chk("midreset_valid_after_late", 32'(bus.sample_valid), 32'd0);

    dly_a = 2; dly_b = 2; data_a = 16'h0FF0; data_b = 16'h0330;
    b0 = n_drdy;
    step(1'b1);
    run_until_drdy(b0, 1);
    repeat (3) step(1'b0);
    chk("recover_drdy_count", 32'(n_drdy - b0), 32'd1);
    chk("recover_sample_valid", 32'(bus.sample_valid), 32'd1);

`ifdef SAMPLE_AVG_EN
    begin
      int vals[4];
      int avgs[4];
      vals = '{100, 200, 300, 400};
      avgs = '{100, 125, 175, 250};
      reset_in = 1'b1;
      repeat (2) step(1'b0);
      reset_in = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
        dly_a = 1; dly_b = 2;
        data_a = 16'(vals[i] << 4);
        data_b = 16'(vals[i] << 4);
        b0 = n_drdy;
        step(1'b1);
        run_until_drdy(b0, 1);
        chk($sformatf("avg_5v_%0d", i), 32'(bus.volt_5v_out), 32'(avgs[i]));
        repeat (2) step(1'b0);
      end
    end
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
